instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 RESET_PC, 32'h00002000, address of the first fetch after reset (successor of the 32'h00001FFC PC reset value).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  branch/jump redirect strobe from execute.
REQ-005 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-006 imem_req_valid  output  1  instruction memory request valid.
REQ-007 imem_req_ready  input  1  memory accepts request when valid&ready.
REQ-008 imem_req_addr  output  32  request address (current fetch PC).
REQ-009 imem_resp_valid  input  1  memory response strobe; in order, no backpressure.
REQ-010 imem_resp_data  input  32  returned instruction word.
REQ-011 inst_valid  output  1  decoded-stage instruction available.
REQ-012 inst_ready  input  1  downstream consumes when inst_valid&inst_ready.
REQ-013 inst_data  output  32  instruction word at FIFO head.
REQ-014 inst_pc  output  32  address of inst_data.

Function
REQ-015 State: fetch_pc (32b), pc_q (2-entry address queue of in-flight requests), out_fifo (2 entries of {pc,data}), outst (0..2), drop_cnt (0..2).
REQ-016 Credit rule: imem_req_valid = !reset & !redirect_valid & (outst + fifo_count < 2); never exceeds 2 in flight+buffered.
REQ-017 imem_req_addr = fetch_pc; on req handshake, push fetch_pc to pc_q, outst+1, fetch_pc <= fetch_pc+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0).
REQ-018 imem_req_valid, once asserted, holds addr stable until handshake or redirect.
REQ-019 Response with drop_cnt=0: pop pc_q head, push {head,imem_resp_data} to out_fifo, outst-1.
REQ-020 Response with drop_cnt>0: pop pc_q, discard data, outst-1, drop_cnt-1.
REQ-021 Latency: response in cycle N -> inst_valid=1 with that word in cycle N+1 (empty FIFO case).
REQ-022 inst_valid = out_fifo non-empty; inst_data/inst_pc = FIFO head; pop on inst_valid&inst_ready.
REQ-023 Same-cycle push and pop on out_fifo legal at any occupancy, including full (count unchanged).
REQ-024 Redirect (highest priority): out_fifo flushed (inst_valid=0 next cycle), fetch_pc <= redirect_pc, no request issued that cycle.
REQ-025 Redirect drop count: drop_cnt <= outst after this cycle's response accounting (e.g. outst=2 plus response same cycle -> drop_cnt=1); same-cycle response discarded.
REQ-026 Redirect while drop_cnt>0: drop_cnt recomputed per REQ-025 (remaining outstanding all dropped).
REQ-027 Redirect concurrent with inst handshake: flush wins; popped word still counts as consumed by downstream.
REQ-028 Requests to redirect_pc issue while drop_cnt>0 if credit permits; ordering guarantees stale responses arrive first.
REQ-029 redirect_pc low two bits passed through unmodified (alignment is caller's responsibility).

Reset
REQ-030 Reset asserted: fetch_pc=RESET_PC, outst=0, drop_cnt=0, FIFO and pc_q empty, imem_req_valid=0, inst_valid=0.
REQ-031 Reset mid-operation discards all in-flight and buffered state; responses arriving during or after reset for pre-reset requests are not the bench's concern (memory reset together).
REQ-032 First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=32'h00002000.

Verification
REQ-033 Reset release, ready=1, 1-cycle memory -> requests 0x2000,0x2004,0x2008; inst_pc sequence 0x2000,0x2004,... with matching data.
REQ-034 inst_ready=0 for 10 cycles -> at most 2 requests issued, imem_req_valid=0 until a pop frees credit.
REQ-035 2 outstanding (0x2000,0x2004), redirect_pc=0x3000 -> both responses dropped, first inst_pc=0x3000.
REQ-036 Redirect in same cycle as response and inst handshake -> drop_cnt=outst-1, FIFO empty next cycle, no stale inst_pc seen.
REQ-037 redirect_pc=0xFFFFFFFC -> next request addr 0x00000000 after wrap.
REQ-038 Reset asserted with full FIFO and outst=2 -> next cycle inst_valid=0, imem_req_valid=0; after release first addr 0x2000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tracking, stale-response dropping after redirects and a 2-entry output buffer.

module instr_fetch_q #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    // Push and pop on a full queue is safe: the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    logic [31:0] fetch_pc;
    logic [1:0]  drop_cnt;
    logic [1:0]  outst;
    logic [1:0]  fifo_cnt;
    logic [31:0] pcq_head;
    inst_t       fifo_head;
    inst_t       fifo_wdata;

    logic credit_ok;
    logic req_fire;
    logic resp_fire;
    logic resp_keep;
    logic inst_fire;
    logic [1:0] outst_after_resp;

    // Outstanding requests plus buffered words never exceed two, so a
    // response always finds room in the output buffer.
    assign credit_ok = ({1'b0, outst} + {1'b0, fifo_cnt}) < 3'd2;

    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_fire  = imem_resp_valid && (outst != 2'd0);
    assign resp_keep  = resp_fire && (drop_cnt == 2'd0) && !redirect_valid;
    assign inst_fire  = inst_valid && inst_ready && !redirect_valid;

    assign outst_after_resp = outst - 2'(resp_fire);

    // In-flight request addresses; its occupancy doubles as the outstanding count.
    instr_fetch_q #(.W(32), .DEPTH(2)) u_pc_q (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (resp_fire),
        .rdata (pcq_head),
        .count (outst)
    );

    assign fifo_wdata = '{pc: pcq_head, data: imem_resp_data};

    instr_fetch_q #(.W($bits(inst_t)), .DEPTH(2)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (resp_keep),
        .wdata (fifo_wdata),
        .pop   (inst_fire),
        .rdata (fifo_head),
        .count (fifo_cnt)
    );

    assign inst_valid = (fifo_cnt != 2'd0);
    assign inst_data  = fifo_head.data;
    assign inst_pc    = fifo_head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= 2'd0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            drop_cnt <= outst_after_resp;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (resp_fire && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, backpressure, redirects,
// address wrap and mid-operation reset.

module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        auto_en;
    logic        auto_v = 1'b0;
    logic [31:0] auto_d = '0;
    logic        man_v;
    logic [31:0] man_d;
    int          hs_cnt = 0;
    int          h0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    // One-cycle memory returning addr ^ 32'hC0DE0000, or manually driven responses.
    always @(posedge clk) begin
        if (reset) begin
            auto_v <= 1'b0;
        end else begin
            auto_v <= auto_en && imem_req_valid && imem_req_ready;
            auto_d <= imem_req_addr ^ 32'hC0DE_0000;
            if (imem_req_valid && imem_req_ready) hs_cnt <= hs_cnt + 1;
        end
    end

    assign imem_resp_valid = auto_en ? auto_v : man_v;
    assign imem_resp_data  = auto_en ? auto_d : man_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 1;
        man_v = 0; man_d = '0; inst_ready = 1; auto_en = 1;
        step(); step();
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", imem_req_addr, 32'h0000_2000);

        // Streaming with a 1-cycle memory
        reset = 0; #1;
        chk("a0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("a0_addr", imem_req_addr, 32'h0000_2000);
        step(); #1;
        chk("a1_addr", imem_req_addr, 32'h0000_2004);
        chk("a1_inst_valid", 32'(inst_valid), 32'd0);
        step(); #1;
        chk("a2_inst_valid", 32'(inst_valid), 32'd1);
        chk("a2_inst_pc", inst_pc, 32'h0000_2000);
        chk("a2_inst_data", inst_data, 32'hC0DE_2000);
        chk("a2_req_valid", 32'(imem_req_valid), 32'd0);
        step(); #1;
        chk("a3_inst_pc", inst_pc, 32'h0000_2004);
        chk("a3_inst_data", inst_data, 32'hC0DE_2004);
        chk("a3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("a3_addr", imem_req_addr, 32'h0000_2008);
        step(); #1;
        chk("a4_inst_valid", 32'(inst_valid), 32'd0);
        step(); #1;
        chk("a5_inst_pc", inst_pc, 32'h0000_2008);
        chk("a5_inst_data", inst_data, 32'hC0DE_2008);

        // Downstream stall: credit limits issue to two
        reset = 1; inst_ready = 0; step();
        reset = 0; h0 = hs_cnt;
        repeat (10) step();
        #1;
        chk("b_hs_count", 32'(hs_cnt - h0), 32'd2);
        chk("b_req_valid", 32'(imem_req_valid), 32'd0);
        chk("b_inst_pc", inst_pc, 32'h0000_2000);
        inst_ready = 1; #1;
        chk("b_pop_req_valid", 32'(imem_req_valid), 32'd0);
        step(); #1;
        chk("b_after_pop_pc", inst_pc, 32'h0000_2004);
        chk("b_after_pop_req", 32'(imem_req_valid), 32'd1);
        chk("b_after_pop_addr", imem_req_addr, 32'h0000_2008);
        inst_ready = 0;
        step(); #1;
        chk("b_full_inst_pc", inst_pc, 32'h0000_2004);
        chk("b_full_req_valid", 32'(imem_req_valid), 32'd0);
        // Reset with a full buffer
        reset = 1; step(); #1;
        chk("b_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("b_rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Redirect with two outstanding: both stale responses dropped
        reset = 0; auto_en = 0; inst_ready = 1; #1;
        chk("c0_addr", imem_req_addr, 32'h0000_2000);
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        step(); #1;
        chk("c1_addr", imem_req_addr, 32'h0000_2004);
        step(); #1;
        chk("c2_req_valid_full", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1; redirect_pc = 32'h0000_3000;
        step();
        redirect_valid = 0; man_v = 1; man_d = 32'hC0DE_2000; #1;
        chk("c3_req_valid", 32'(imem_req_valid), 32'd0);
        chk("c3_inst_valid", 32'(inst_valid), 32'd0);
        step();
        man_d = 32'hC0DE_2004; #1;
        chk("c4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c4_addr", imem_req_addr, 32'h0000_3000);
        chk("c4_inst_valid", 32'(inst_valid), 32'd0);
        step();
        man_d = 32'hC0DE_3000; #1;
        chk("c5_addr", imem_req_addr, 32'h0000_3004);
        chk("c5_inst_valid", 32'(inst_valid), 32'd0);
        step();
        // Redirect together with a response and an instruction handshake
        man_d = 32'hC0DE_3004; redirect_valid = 1; redirect_pc = 32'h0000_4000; #1;
        chk("c6_inst_pc", inst_pc, 32'h0000_3000);
        chk("c6_inst_data", inst_data, 32'hC0DE_3000);
        chk("c6_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 0; man_v = 0; #1;
        chk("c7_inst_valid", 32'(inst_valid), 32'd0);
        chk("c7_addr", imem_req_addr, 32'h0000_4000);
        chk("c7_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        man_v = 1; man_d = 32'hC0DE_4000; #1;
        chk("c8_inst_valid", 32'(inst_valid), 32'd0);
        chk("c8_addr", imem_req_addr, 32'h0000_4004);
        step();
        man_v = 0; #1;
        chk("c9_inst_valid", 32'(inst_valid), 32'd1);
        chk("c9_inst_pc", inst_pc, 32'h0000_4000);
        chk("c9_inst_data", inst_data, 32'hC0DE_4000);

        // Redirect to the top of the address space, then wrap
        reset = 1; step();
        reset = 0; auto_en = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("e0_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 0; #1;
        chk("e1_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("e1_req_valid", 32'(imem_req_valid), 32'd1);
        step(); #1;
        chk("e2_addr_wrap", imem_req_addr, 32'h0000_0000);
        step(); #1;
        chk("e3_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("e3_inst_data", inst_data, 32'h3F21_FFFC);
        step(); #1;
        chk("e4_inst_pc", inst_pc, 32'h0000_0000);
        chk("e4_inst_data", inst_data, 32'hC0DE_0000);

        // Reset with two requests outstanding
        auto_en = 0; reset = 1; step();
        reset = 0; step(); step(); #1;
        chk("f_outst2_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1; step(); #1;
        chk("f_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("f_rst_inst_valid", 32'(inst_valid), 32'd0);
        reset = 0; #1;
        chk("f_rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("f_rel_addr", imem_req_addr, 32'h0000_2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
